// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-digit common-anode
// 7-segment display. Eight 4-bit digit registers are loaded through a write
// port, and a prescaled scan counter picks one digit per slot. The anode
// enables and the segments are active-low and registered.
module seg7_scan_driver #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_mask,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic [2:0] scan_idx,
  output logic       frame_tick
);

  localparam logic [23:0] DIV_LAST = 24'(CLK_DIV - 1);

  logic [3:0]  r_digit [8];
  logic [23:0] r_presc;
  logic [2:0]  r_scan_idx;
  logic        r_frame_tick;
  logic [7:0]  r_an;
  logic [6:0]  r_seg;

  logic        w_slot_end;
  logic [3:0]  w_cur_digit;
  logic [6:0]  w_seg_enc;

  // Slot boundary detect and selection of the digit under scan
  always_comb begin
    w_slot_end  = (r_presc == DIV_LAST);
    w_cur_digit = r_digit[r_scan_idx];
  end

  // Hex to active-low segment pattern, bit order g..a
  always_comb begin
    w_seg_enc = 7'h7F;
    case (w_cur_digit)
      4'h0: w_seg_enc = 7'h40;
      4'h1: w_seg_enc = 7'h79;
      4'h2: w_seg_enc = 7'h24;
      4'h3: w_seg_enc = 7'h30;
      4'h4: w_seg_enc = 7'h19;
      4'h5: w_seg_enc = 7'h12;
      4'h6: w_seg_enc = 7'h02;
      4'h7: w_seg_enc = 7'h78;
      4'h8: w_seg_enc = 7'h00;
      4'h9: w_seg_enc = 7'h10;
      4'hA: w_seg_enc = 7'h08;
      4'hB: w_seg_enc = 7'h03;
      4'hC: w_seg_enc = 7'h46;
      4'hD: w_seg_enc = 7'h21;
      4'hE: w_seg_enc = 7'h06;
      4'hF: w_seg_enc = 7'h0E;
      default: w_seg_enc = 7'h7F;
    endcase
  end

  // Digit register file; writes are always accepted, independent of scanning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) r_digit[i] <= '0;
    end else if (wr_en) begin
      r_digit[wr_addr] <= wr_data;
    end
  end

  // Prescaler and scan index; both freeze while the display is disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_scan_idx   <= '0;
      r_frame_tick <= 1'b0;
    end else if (en) begin
      if (w_slot_end) begin
        r_presc    <= '0;
        r_scan_idx <= r_scan_idx + 3'd1;
      end else begin
        r_presc    <= r_presc + 24'd1;
      end
      r_frame_tick <= w_slot_end && (r_scan_idx == 3'd7);
    end else begin
      r_frame_tick <= 1'b0;
    end
  end

  // Registered output stage: one-hot low anode and segments for the current slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '1;
      r_seg <= '1;
    end else if (en && digit_mask[r_scan_idx]) begin
      r_an  <= ~(8'b1 << r_scan_idx);
      r_seg <= w_seg_enc;
    end else begin
      r_an  <= '1;
      r_seg <= '1;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign scan_idx   = r_scan_idx;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver. It runs two instances side by side:
// CLK_DIV=4 and CLK_DIV=1. The reference model counts enabled clock edges
// and derives the slot from that count with plain arithmetic.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [7:0] digit_mask = '0;

  logic [7:0] an4, an1;
  logic [6:0] seg4, seg1;
  logic [2:0] idx4, idx1;
  logic       ft4, ft1;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_scan_driver #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .digit_mask(digit_mask), .an(an4), .seg(seg4),
    .scan_idx(idx4), .frame_tick(ft4));

  seg7_scan_driver #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .digit_mask(digit_mask), .an(an1), .seg(seg1),
    .scan_idx(idx1), .frame_tick(ft1));

  // Reference model: m_cnt counts enabled edges since reset
  int unsigned m_cnt;
  logic [3:0]  m_dig [8];
  logic [7:0]  m_an4, m_an1;
  logic [6:0]  m_seg4, m_seg1;
  logic        m_ft4, m_ft1;

  always @(posedge clk or negedge rst_n) begin
    int unsigned s4, s1;
    if (!rst_n) begin
      m_cnt = 0;
      for (int i = 0; i < 8; i++) m_dig[i] = '0;
      m_an4 = 8'hFF; m_an1 = 8'hFF; m_seg4 = 7'h7F; m_seg1 = 7'h7F;
      m_ft4 = 1'b0; m_ft1 = 1'b0;
    end else begin
      s4 = (m_cnt / 4) % 8;
      s1 = m_cnt % 8;
      if (en && digit_mask[s4]) begin
        m_an4 = 8'hFF ^ (8'h01 << s4); m_seg4 = seg_tbl[m_dig[s4]];
      end else begin
        m_an4 = 8'hFF; m_seg4 = 7'h7F;
      end
      if (en && digit_mask[s1]) begin
        m_an1 = 8'hFF ^ (8'h01 << s1); m_seg1 = seg_tbl[m_dig[s1]];
      end else begin
        m_an1 = 8'hFF; m_seg1 = 7'h7F;
      end
      if (en) m_cnt++;
      m_ft4 = en && (m_cnt % 32 == 0);
      m_ft1 = en && (m_cnt % 8 == 0);
      if (wr_en) m_dig[wr_addr] = wr_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #12;
    checks++;
    if ({an4, seg4, idx4, ft4} !== {8'hFF, 7'h7F, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_div4: got an=%h seg=%h idx=%0d ft=%b, required FF 7F 0 0", an4, seg4, idx4, ft4);
    end
    checks++;
    if ({an1, seg1, idx1, ft1} !== {8'hFF, 7'h7F, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_div1: got an=%h seg=%h idx=%0d ft=%b, required FF 7F 0 0", an1, seg1, idx1, ft1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int ft4_cnt = 0, ft1_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    en = 1'b1; digit_mask = 8'hFF;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      checks++;
      if ({an4, seg4, idx4, ft4, an1, seg1, idx1, ft1} !==
          {m_an4, m_seg4, 3'((m_cnt / 4) % 8), m_ft4, m_an1, m_seg1, 3'(m_cnt % 8), m_ft1}) begin
        errors++;
        $display("FAIL scan_model: got an4=%h seg4=%h idx4=%0d ft4=%b an1=%h seg1=%h idx1=%0d ft1=%b, required %h %h %0d %b %h %h %0d %b",
                 an4, seg4, idx4, ft4, an1, seg1, idx1, ft1,
                 m_an4, m_seg4, (m_cnt / 4) % 8, m_ft4, m_an1, m_seg1, m_cnt % 8, m_ft1);
      end
      if (an4 == 8'hF7) begin
        checks++;
        if (seg4 !== 7'h30) begin
          errors++;
          $display("FAIL scan_slot3_seg: got %h, required 30", seg4);
        end
      end
      if (an4 == 8'h7F) begin
        checks++;
        if (seg4 !== 7'h78) begin
          errors++;
          $display("FAIL scan_slot7_seg: got %h, required 78", seg4);
        end
      end
      if (ft4) ft4_cnt++;
      if (ft1) ft1_cnt++;
    end
    checks++;
    if (ft4_cnt != 2) begin
      errors++;
      $display("FAIL scan_frame_tick_div4: got %0d pulses in 64 cycles, required 2", ft4_cnt);
    end
    checks++;
    if (ft1_cnt != 8) begin
      errors++;
      $display("FAIL scan_frame_tick_div1: got %0d pulses in 64 cycles, required 8", ft1_cnt);
    end
  endtask

  task automatic test_write_latency();
    for (int k = 0; k < 40 && idx4 !== 3'd1; k++) @(negedge clk);
    for (int k = 0; k < 40 && idx4 !== 3'd2; k++) @(negedge clk);
    checks++;
    if (idx4 !== 3'd2) begin
      errors++;
      $display("FAIL wrlat_wait: got idx=%0d, required 2 within budget", idx4);
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'hF;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if ({an4, seg4} !== {8'hFB, 7'h24}) begin
      errors++;
      $display("FAIL wrlat_edge1: got an=%h seg=%h, required FB 24", an4, seg4);
    end
    @(negedge clk);
    checks++;
    if ({an4, seg4} !== {8'hFB, 7'h0E}) begin
      errors++;
      $display("FAIL wrlat_edge2: got an=%h seg=%h, required FB 0E", an4, seg4);
    end
  endtask

  task automatic test_mask();
    int prev;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    digit_mask = 8'h55;
    prev = int'(idx4);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (prev % 2 == 1) begin
        if ({an4, seg4} !== {8'hFF, 7'h7F}) begin
          errors++;
          $display("FAIL mask_odd_slot%0d: got an=%h seg=%h, required FF 7F", prev, an4, seg4);
        end
      end else if ({an4, seg4} !== {8'hFF ^ (8'h01 << prev), seg_tbl[m_dig[prev]]}) begin
        errors++;
        $display("FAIL mask_even_slot%0d: got an=%h seg=%h, required %h %h",
                 prev, an4, seg4, 8'hFF ^ (8'h01 << prev), seg_tbl[m_dig[prev]]);
      end
      prev = int'(idx4);
    end
    digit_mask = 8'hFF;
  endtask

  task automatic test_enable();
    int n = 0;
    for (int k = 0; k < 40 && idx4 !== 3'd4; k++) @(negedge clk);
    for (int k = 0; k < 40 && idx4 !== 3'd5; k++) @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({an4, seg4, idx4, ft4} !== {8'hFF, 7'h7F, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL en_drop: got an=%h seg=%h idx=%0d ft=%b, required FF 7F 5 0", an4, seg4, idx4, ft4);
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if ({an4, idx4} !== {8'hFF, 3'd5}) begin
        errors++;
        $display("FAIL en_hold: got an=%h idx=%0d, required FF 5", an4, idx4);
      end
    end
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n++;
      if (idx4 == 3'd6) break;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL en_resume: got %0d edges to reach slot 6, required 3", n);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 40 && idx4 !== 3'd5; k++) @(negedge clk);
    for (int k = 0; k < 40 && idx4 !== 3'd6; k++) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an4, seg4, idx4, ft4, an1, idx1} !== {8'hFF, 7'h7F, 3'd0, 1'b0, 8'hFF, 3'd0}) begin
      errors++;
      $display("FAIL async_reset: got an4=%h seg4=%h idx4=%0d ft4=%b an1=%h idx1=%0d, required FF 7F 0 0 FF 0",
               an4, seg4, idx4, ft4, an1, idx1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (seg4 !== 7'h40 || an4 === 8'hFF) begin
        errors++;
        $display("FAIL post_reset_digits: got an=%h seg=%h, required active anode with seg 40", an4, seg4);
      end
    end
  endtask

  task automatic test_div1();
    logic [7:0] prev_an;
    int ft_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'h8;
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    prev_an = an1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      checks++;
      if (seg1 !== 7'h00 || an1 !== {prev_an[6:0], prev_an[7]} || an1 === 8'h00) begin
        errors++;
        $display("FAIL div1_rotate: got an=%h seg=%h, required an=%h seg=00", an1, seg1, {prev_an[6:0], prev_an[7]});
      end
      if (ft1) ft_cnt++;
      prev_an = an1;
    end
    checks++;
    if (ft_cnt != 3) begin
      errors++;
      $display("FAIL div1_frame_tick: got %0d pulses in 24 cycles, required 3", ft_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if ({an4, seg4, idx4, ft4, an1, seg1, idx1, ft1} !==
          {m_an4, m_seg4, 3'((m_cnt / 4) % 8), m_ft4, m_an1, m_seg1, 3'(m_cnt % 8), m_ft1}) begin
        errors++;
        $display("FAIL random_model: got an4=%h seg4=%h idx4=%0d ft4=%b an1=%h seg1=%h idx1=%0d ft1=%b, required %h %h %0d %b %h %h %0d %b",
                 an4, seg4, idx4, ft4, an1, seg1, idx1, ft1,
                 m_an4, m_seg4, (m_cnt / 4) % 8, m_ft4, m_an1, m_seg1, m_cnt % 8, m_ft1);
      end
      checks++;
      if ($countones(~an4) > 1 || $countones(~an1) > 1) begin
        errors++;
        $display("FAIL random_onehot: got an4=%h an1=%h, required at most one low bit", an4, an1);
      end
      en      = ($urandom_range(0, 7) != 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_addr = 3'($urandom);
      wr_data = 4'($urandom);
      if (c % 16 == 0) digit_mask = 8'($urandom);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_write_latency();
    test_mask();
    test_enable();
    test_async_reset();
    test_div1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for an 8-digit, common-anode 7-segment display.
- Holds eight 4-bit hex digit registers, loaded through a simple write port.
- A prescaled scan counter selects one digit at a time. The counter index is expanded by a 3-to-8 decoder into one-hot active-low anode enables, and the selected digit is converted to active-low segments.
- Sits between an encoder/result path (e.g. a priority-encoder output) and the board display pins.

Parameters:
- CLK_DIV, 50000: clk cycles per digit slot. Legal range 1 to 2^24-1. Prescaler width is 24 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global display enable.
- wr_en  in  1  digit register write strobe.
- wr_addr  in  3  digit index to write.
- wr_data  in  4  hex value to write.
- digit_mask  in  8  per-digit enable; 1 = show the digit, 0 = blank it.
- an  out  8  anode selects, active-low, at most one bit low.
- seg  out  7  segments, active-low. seg[0]=a … seg[6]=g.
- scan_idx  out  3  digit slot currently being scanned.
- frame_tick  out  1  one-cycle pulse when scan_idx wraps from 7 to 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - digit regs = 0, prescaler = 0, scan_idx = 0.
  - an = 8'hFF, seg = 7'h7F, frame_tick = 0.
  - Reset asserted mid-scan or mid-write is immediate; any write in progress is lost.
- Write port:
  - When wr_en=1 at a rising edge, digit[wr_addr] <= wr_data.
  - No handshake; writes are always accepted.
  - A write and a scan step in the same cycle are independent.
- Prescaler (only while en=1):
  - Counts 0 to CLK_DIV-1.
  - At CLK_DIV-1 it returns to 0 and scan_idx increments mod 8 (7 wraps to 0).
  - With CLK_DIV=1, scan_idx advances every cycle.
- frame_tick: registered; equals 1 in the cycle immediately after scan_idx changes 7 to 0, otherwise 0.
- Output stage (registered, 1-cycle latency from scan_idx, digit regs, digit_mask and en):
  - en=1 and digit_mask[scan_idx]=1: an = ~(8'b1 << scan_idx); seg = encode(digit[scan_idx]).
  - en=1 and digit_mask[scan_idx]=0: an = 8'hFF, seg = 7'h7F.
  - en=0: an = 8'hFF, seg = 7'h7F; prescaler and scan_idx hold their values; frame_tick = 0.
- Latency: a write to the digit currently being displayed appears on seg two edges after the wr_en edge.
- Segment encoding, bits g..a, active-low, hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Invariant: an never has more than one low bit in any cycle, including the cycle in which scan_idx wraps.
- Re-enable: when en returns to 1, scanning resumes from the held prescaler and scan_idx values; no restart.

Test Plan:
- Reset, then write digit i = i for i = 0..7, digit_mask=FF, en=1, CLK_DIV=4 -> scan_idx steps every 4 cycles; at slot 3, an=F7 and seg=30; at slot 7, an=7F and seg=78; frame_tick high exactly one cycle per 32 cycles.
- While slot 2 is displayed, write wr_addr=2, wr_data=F -> seg changes 24 to 0E two edges after the write; an is unchanged.
- digit_mask=0x55, full scan -> odd slots show an=FF and seg=7F; even slots show a one-hot low anode and the correct segments.
- Drop en for 10 cycles mid-slot 5 -> an=FF and seg=7F one edge later; scan_idx holds at 5; after en returns, slot 5 completes its remaining prescaler count.
- Assert rst_n=0 asynchronously between edges during slot 6 -> an=FF, seg=7F, scan_idx=0 immediately; all digits read back as 0 (seg=40) after release.
- CLK_DIV=1, all digits = 8 -> an rotates FE, FD, … 7F on consecutive cycles with seg=00; frame_tick pulses every 8 cycles; an is never all-low.
